pred_raw_array: RTL and testbench
=================================

PRED_RAW_ARRAY -- requirements
Module: pred_raw_array

Interface
REQ-001 Parameter WIDTH, default 32: state and packet-field width, in bits.
REQ-002 Parameter DEPTH, default 8: number of state slots; legal values are powers of two, 2 or more. IW = clog2(DEPTH).
REQ-003 Parameter SIGNED, default 0: 1 makes the ordered compares (<, >) two's-complement; 0 makes them unsigned.
REQ-004 clk  in  1  single clock; all flops update on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  a packet is presented this cycle.
REQ-007 idx  in  IW  state slot addressed by the packet.
REQ-008 pkt_1, pkt_2  in  WIDTH each  packet fields.
REQ-009 cons_1, cons_2, cons_3  in  WIDTH each  constants.
REQ-010 sel_1, sel_3, sel_5  in  1 each  2-way selects: 0 selects state, 1 selects zero.
REQ-011 sel_2, sel_4, sel_6  in  2 each  3-way selects: 0 selects pkt_1, 1 selects pkt_2, 2 or 3 selects the constant.
REQ-012 rel_opcode  in  2  compare: 0 is !=, 1 is <, 2 is >, 3 is ==.
REQ-013 clr  in  1  synchronous clear of all slots.
REQ-014 out_valid  out  1  result valid.
REQ-015 o__idx  out  IW  slot of the result.
REQ-016 o__read  out  WIDTH  slot value before the update.
REQ-017 o__write  out  WIDTH  slot value after the update.

Function
REQ-018 Stage A, on the edge that samples in_valid=1:
- capture all packet inputs and idx;
- capture rd = state[idx], subject to forwarding (REQ-022).
REQ-019 Stage B computes from the captured values: if rel(mux2(rd,0,sel_1), mux3(pkt_1,pkt_2,cons_1,sel_2)) then wr = mux2(rd,0,sel_3) + mux3(pkt_1,pkt_2,cons_2,sel_4), else wr = mux2(rd,0,sel_5) + mux3(pkt_1,pkt_2,cons_3,sel_6).
REQ-020 The addition wraps modulo 2^WIDTH; no carry out and no saturation.
REQ-021 At the end of stage B:
- state[idx] is written with wr;
- out_valid=1, o__idx=idx, o__read=rd, o__write=wr are registered.
- Latency from the in_valid edge to out_valid is exactly 2 edges.
REQ-022 Forwarding: when stage B is valid with the same idx as the packet entering stage A, rd takes stage B's wr rather than the array value, so back-to-back same-slot packets see read-after-write order.
REQ-023 Full throughput: one packet per cycle, no stall and no backpressure; in_valid=0 creates a bubble.
REQ-024 out_valid is deasserted whenever stage B was empty; the other outputs then hold their previous values.
REQ-025 clr=1 at an edge:
- sets every slot to 0;
- suppresses any stage B array write at that edge (its outputs still emit);
- makes a packet entering stage A at that edge capture rd=0.
REQ-026 Slots other than the addressed slot do not change, except on clr or reset.

Reset
REQ-027 rst=1 immediately clears all slots, both stage valid bits, out_valid, o__idx, o__read and o__write to 0, independent of clk.
REQ-028 rst asserted mid-operation discards in-flight packets; the first packet accepted after rst deasserts reads 0.

Structure
REQ-029 A shared package holds the 2-bit opcode constants (OPC_NE=0, OPC_LT=1, OPC_GT=2, OPC_EQ=3) and the 1-bit and 2-bit select typedefs.
REQ-030 Combinational sub-module pred_raw_alu (parameters WIDTH, SIGNED) implements REQ-019.
REQ-031 The slot array is flops, not RAM, so REQ-027 holds.

Verification
REQ-032 Reset, then a packet with idx=3, pkt_1=5, sel_2=0, rel_opcode=3, sel_1=0, sel_3=0, sel_4=0 -> 0==5 is false, so the else path runs; with sel_5=0, sel_6=2, cons_3=7 -> o__read=0, o__write=7, out_valid exactly 2 edges later.
REQ-033 Back-to-back: three consecutive packets to idx=1 computing state + pkt_1 with pkt_1=1 -> o__write=1, 2, 3 (forwarding proven).
REQ-034 Interleaved idx 0, 1, 0, 1 adding 10 each -> slot 0 and slot 1 each reach 20, with no cross-slot corruption.
REQ-035 WIDTH=8: state 250 + 10 -> o__write=4. SIGNED=1: state 0xFF compared < 1 is true; SIGNED=0: the same compare is false.
REQ-036 clr on the edge where an idx=2 packet is in stage B -> that packet's outputs emit, slot 2 reads 0 afterwards; a following same-slot packet reads o__read=0.
REQ-037 rst pulsed between clock edges while 2 packets are in flight -> out_valid stays 0 and all slots read 0.

Source files
------------

// File: rtl/pred_raw_array_pkg.sv
// Shared types and compare opcodes for the predicated read-modify-write slot array.
package pred_raw_array_pkg;

  localparam logic [1:0] OPC_NE = 2'd0;
  localparam logic [1:0] OPC_LT = 2'd1;
  localparam logic [1:0] OPC_GT = 2'd2;
  localparam logic [1:0] OPC_EQ = 2'd3;

  // 2-way select: 0 picks the slot value, 1 picks zero.
  typedef logic       sel2_t;
  // 3-way select: 0 pkt_1, 1 pkt_2, 2/3 the per-site constant.
  typedef logic [1:0] sel3_t;
  typedef logic [1:0] opc_t;

endpackage

// File: rtl/pred_raw_array_if.sv
// Packet-in / result-out bundle for pred_raw_array.
interface pred_raw_array_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  import pred_raw_array_pkg::*;

  localparam int IW = $clog2(DEPTH);

  logic             in_valid;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] pkt_1;
  logic [WIDTH-1:0] pkt_2;
  logic [WIDTH-1:0] cons_1;
  logic [WIDTH-1:0] cons_2;
  logic [WIDTH-1:0] cons_3;
  sel2_t            sel_1;
  sel2_t            sel_3;
  sel2_t            sel_5;
  sel3_t            sel_2;
  sel3_t            sel_4;
  sel3_t            sel_6;
  opc_t             rel_opcode;
  logic             clr;

  logic             out_valid;
  logic [IW-1:0]    o__idx;
  logic [WIDTH-1:0] o__read;
  logic [WIDTH-1:0] o__write;

  modport master (
    output in_valid, idx, pkt_1, pkt_2, cons_1, cons_2, cons_3,
           sel_1, sel_3, sel_5, sel_2, sel_4, sel_6, rel_opcode, clr,
    input  out_valid, o__idx, o__read, o__write
  );

  modport slave (
    input  in_valid, idx, pkt_1, pkt_2, cons_1, cons_2, cons_3,
           sel_1, sel_3, sel_5, sel_2, sel_4, sel_6, rel_opcode, clr,
    output out_valid, o__idx, o__read, o__write
  );

endinterface

// File: rtl/pred_raw_array_alu.sv
// Combinational predicate + update: picks one of two sums depending on an ordered/equality compare.
module pred_raw_alu
  import pred_raw_array_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] rd,
  input  logic [WIDTH-1:0] pkt_1,
  input  logic [WIDTH-1:0] pkt_2,
  input  logic [WIDTH-1:0] cons_1,
  input  logic [WIDTH-1:0] cons_2,
  input  logic [WIDTH-1:0] cons_3,
  input  sel2_t            sel_1,
  input  sel2_t            sel_3,
  input  sel2_t            sel_5,
  input  sel3_t            sel_2,
  input  sel3_t            sel_4,
  input  sel3_t            sel_6,
  input  opc_t             rel_opcode,
  output logic [WIDTH-1:0] wr
);

  function automatic logic [WIDTH-1:0] mux2(logic [WIDTH-1:0] st, sel2_t sel);
    return sel ? {WIDTH{1'b0}} : st;
  endfunction

  function automatic logic [WIDTH-1:0] mux3(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                            logic [WIDTH-1:0] c, sel3_t sel);
    case (sel)
      2'd0:    return a;
      2'd1:    return b;
      default: return c;
    endcase
  endfunction

  function automatic logic rel(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, opc_t op);
    logic lt;
    logic gt;
    if (SIGNED != 0) begin
      lt = $signed(a) < $signed(b);
      gt = $signed(a) > $signed(b);
    end else begin
      lt = a < b;
      gt = a > b;
    end
    case (op)
      OPC_NE:  return a != b;
      OPC_LT:  return lt;
      OPC_GT:  return gt;
      default: return a == b;
    endcase
  endfunction

  // Carry out is dropped on purpose: slots are modular counters.
  function automatic logic [WIDTH-1:0] add_wrap(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    return a + b;
  endfunction

  logic take;

  always_comb begin
    take = rel(mux2(rd, sel_1), mux3(pkt_1, pkt_2, cons_1, sel_2), rel_opcode);
    if (take) wr = add_wrap(mux2(rd, sel_3), mux3(pkt_1, pkt_2, cons_2, sel_4));
    else      wr = add_wrap(mux2(rd, sel_5), mux3(pkt_1, pkt_2, cons_3, sel_6));
  end

endmodule

// File: rtl/pred_raw_array.sv
// Two-stage read-modify-write over a flop-based slot array, with stage-B to stage-A forwarding.
module pred_raw_array
  import pred_raw_array_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic            clk,
  input  logic            rst,
  pred_raw_array_if.slave bus
);

  localparam int IW = $clog2(DEPTH);

  logic [WIDTH-1:0] state_q [DEPTH];

  logic             vld_p0;
  logic [IW-1:0]    idx_p0;
  logic [WIDTH-1:0] rd_p0;
  logic [WIDTH-1:0] pkt1_p0;
  logic [WIDTH-1:0] pkt2_p0;
  logic [WIDTH-1:0] cons1_p0;
  logic [WIDTH-1:0] cons2_p0;
  logic [WIDTH-1:0] cons3_p0;
  sel2_t            sel1_p0;
  sel2_t            sel3_p0;
  sel2_t            sel5_p0;
  sel3_t            sel2_p0;
  sel3_t            sel4_p0;
  sel3_t            sel6_p0;
  opc_t             opc_p0;

  logic [WIDTH-1:0] rd_fwd;
  logic [WIDTH-1:0] wr_p0;

  logic             vld_p1;
  logic [IW-1:0]    idx_p1;
  logic [WIDTH-1:0] rd_p1;
  logic [WIDTH-1:0] wr_p1;

  // Clear wins over forwarding; forwarding wins over the (stale) array value.
  always_comb begin
    if (bus.clr)                             rd_fwd = '0;
    else if (vld_p0 && (idx_p0 == bus.idx)) rd_fwd = wr_p0;
    else                                     rd_fwd = state_q[bus.idx];
  end

  // ---- stage A: capture packet and read slot ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      idx_p0   <= bus.idx;
      rd_p0    <= rd_fwd;
      pkt1_p0  <= bus.pkt_1;
      pkt2_p0  <= bus.pkt_2;
      cons1_p0 <= bus.cons_1;
      cons2_p0 <= bus.cons_2;
      cons3_p0 <= bus.cons_3;
      sel1_p0  <= bus.sel_1;
      sel3_p0  <= bus.sel_3;
      sel5_p0  <= bus.sel_5;
      sel2_p0  <= bus.sel_2;
      sel4_p0  <= bus.sel_4;
      sel6_p0  <= bus.sel_6;
      opc_p0   <= bus.rel_opcode;
    end
  end

  pred_raw_alu #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_alu (
    .rd         (rd_p0),
    .pkt_1      (pkt1_p0),
    .pkt_2      (pkt2_p0),
    .cons_1     (cons1_p0),
    .cons_2     (cons2_p0),
    .cons_3     (cons3_p0),
    .sel_1      (sel1_p0),
    .sel_3      (sel3_p0),
    .sel_5      (sel5_p0),
    .sel_2      (sel2_p0),
    .sel_4      (sel4_p0),
    .sel_6      (sel6_p0),
    .rel_opcode (opc_p0),
    .wr         (wr_p0)
  );

  // ---- stage B: write back slot and register result ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= '0;
    end else if (bus.clr) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= '0;
    end else if (vld_p0) begin
      state_q[idx_p0] <= wr_p0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      idx_p1 <= '0;
      rd_p1  <= '0;
      wr_p1  <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        idx_p1 <= idx_p0;
        rd_p1  <= rd_p0;
        wr_p1  <= wr_p0;
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.o__idx    = idx_p1;
  assign bus.o__read   = rd_p1;
  assign bus.o__write  = wr_p1;

endmodule

// File: tb/tb_pred_raw_array.sv
// Directed + random bench for pred_raw_array against a sequential slot-array model.
module tb_pred_raw_array;
  import pred_raw_array_pkg::*;

  typedef struct packed {
    logic [2:0]  idx;
    logic [31:0] p1, p2, c1, c2, c3;
    logic        s1, s3, s5;
    logic [1:0]  s2, s4, s6, op;
  } pkt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  pred_raw_array_if #(.WIDTH(32), .DEPTH(8)) b32 ();
  pred_raw_array_if #(.WIDTH(8),  .DEPTH(4)) b8s ();
  pred_raw_array_if #(.WIDTH(8),  .DEPTH(4)) b8u ();

  pred_raw_array #(.WIDTH(32), .DEPTH(8), .SIGNED(0)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  pred_raw_array #(.WIDTH(8),  .DEPTH(4), .SIGNED(1)) dut8s (.clk(clk), .rst(rst), .bus(b8s.slave));
  pred_raw_array #(.WIDTH(8),  .DEPTH(4), .SIGNED(0)) dut8u (.clk(clk), .rst(rst), .bus(b8u.slave));

  // Reference: packets applied one at a time, in arrival order, to a plain array.
  logic [31:0] mstate [8];
  logic        a_v, e_v;
  logic [2:0]  a_idx, e_idx;
  logic [31:0] a_rd, a_wr, e_rd, e_wr;
  pkt_t        cur;
  logic        cur_v, cur_clr;

  function automatic logic [31:0] pick(logic [1:0] s, logic [31:0] p1, logic [31:0] p2, logic [31:0] c);
    return (s == 2'd0) ? p1 : (s == 2'd1) ? p2 : c;
  endfunction

  function automatic logic [31:0] ref_wr(pkt_t p, logic [31:0] rd);
    logic [31:0] lhs, rhs;
    logic        hit;
    lhs = p.s1 ? 32'd0 : rd;
    rhs = pick(p.s2, p.p1, p.p2, p.c1);
    hit = (p.op == 2'd0) ? (lhs != rhs) : (p.op == 2'd1) ? (lhs < rhs) :
          (p.op == 2'd2) ? (lhs > rhs)  : (lhs == rhs);
    if (hit) return (p.s3 ? 32'd0 : rd) + pick(p.s4, p.p1, p.p2, p.c2);
    return (p.s5 ? 32'd0 : rd) + pick(p.s6, p.p1, p.p2, p.c3);
  endfunction

  // Packet that adds val to slot i (always-true predicate 0 == 0).
  function automatic pkt_t mk_add(int i, logic [31:0] val);
    pkt_t p;
    p = '0;
    p.idx = 3'(i);
    p.s1 = 1'b1; p.s2 = 2'd2; p.c1 = 32'd0; p.op = OPC_EQ;
    p.s3 = 1'b0; p.s4 = 2'd0; p.p1 = val;
    return p;
  endfunction

  function automatic logic [31:0] rval();
    return ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 12));
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mstate[i] = 32'd0;
    a_v = 1'b0; e_v = 1'b0; e_idx = 3'd0; e_rd = 32'd0; e_wr = 32'd0;
    a_idx = 3'd0; a_rd = 32'd0; a_wr = 32'd0;
  endtask

  task automatic apply();
    b32.in_valid = cur_v;   b32.clr = cur_clr;   b32.idx = cur.idx;
    b32.pkt_1 = cur.p1;     b32.pkt_2 = cur.p2;
    b32.cons_1 = cur.c1;    b32.cons_2 = cur.c2; b32.cons_3 = cur.c3;
    b32.sel_1 = cur.s1;     b32.sel_3 = cur.s3;  b32.sel_5 = cur.s5;
    b32.sel_2 = cur.s2;     b32.sel_4 = cur.s4;  b32.sel_6 = cur.s6;
    b32.rel_opcode = cur.op;
  endtask

  task automatic drive8(pkt_t p, logic v);
    b8s.in_valid = v;       b8u.in_valid = v;
    b8s.clr = 1'b0;         b8u.clr = 1'b0;
    b8s.idx = p.idx[1:0];   b8u.idx = p.idx[1:0];
    b8s.pkt_1 = p.p1[7:0];  b8u.pkt_1 = p.p1[7:0];
    b8s.pkt_2 = p.p2[7:0];  b8u.pkt_2 = p.p2[7:0];
    b8s.cons_1 = p.c1[7:0]; b8u.cons_1 = p.c1[7:0];
    b8s.cons_2 = p.c2[7:0]; b8u.cons_2 = p.c2[7:0];
    b8s.cons_3 = p.c3[7:0]; b8u.cons_3 = p.c3[7:0];
    b8s.sel_1 = p.s1;       b8u.sel_1 = p.s1;
    b8s.sel_3 = p.s3;       b8u.sel_3 = p.s3;
    b8s.sel_5 = p.s5;       b8u.sel_5 = p.s5;
    b8s.sel_2 = p.s2;       b8u.sel_2 = p.s2;
    b8s.sel_4 = p.s4;       b8u.sel_4 = p.s4;
    b8s.sel_6 = p.s6;       b8u.sel_6 = p.s6;
    b8s.rel_opcode = p.op;  b8u.rel_opcode = p.op;
  endtask

  // One clock edge on the 32-bit DUT: advance the model, then compare all outputs.
  task automatic tick(string tag);
    apply();
    e_v = a_v;
    if (a_v) begin e_idx = a_idx; e_rd = a_rd; e_wr = a_wr; end
    if (cur_clr) for (int i = 0; i < 8; i++) mstate[i] = 32'd0;
    a_v = cur_v;
    if (cur_v) begin
      a_idx = cur.idx;
      a_rd  = mstate[cur.idx];
      a_wr  = ref_wr(cur, a_rd);
      mstate[cur.idx] = a_wr;
    end
    @(posedge clk); #1;
    chk({tag, ".out_valid"}, 32'(b32.out_valid), 32'(e_v));
    chk({tag, ".o__idx"},    32'(b32.o__idx),    32'(e_idx));
    chk({tag, ".o__read"},   b32.o__read,        e_rd);
    chk({tag, ".o__write"},  b32.o__write,       e_wr);
  endtask

  task automatic pulse_reset(string tag);
    #2 rst = 1'b1;
    #2;
    model_reset();
    chk({tag, ".rst_valid"}, 32'(b32.out_valid), 32'd0);
    chk({tag, ".rst_idx"},   32'(b32.o__idx),    32'd0);
    chk({tag, ".rst_read"},  b32.o__read,        32'd0);
    chk({tag, ".rst_write"}, b32.o__write,       32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    pkt_t p;
    cur = '0; cur_v = 1'b0; cur_clr = 1'b0;
    apply();
    drive8('0, 1'b0);
    model_reset();

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk("init.out_valid", 32'(b32.out_valid), 32'd0);
    chk("init.o__read",   b32.o__read,        32'd0);
    chk("init.o__write",  b32.o__write,       32'd0);
    #3 rst = 1'b0;

    // Else path: 0 == 5 false -> 0 + cons_3
    cur = '0; cur.idx = 3'd3; cur.p1 = 32'd5; cur.s2 = 2'd0; cur.op = OPC_EQ;
    cur.s6 = 2'd2; cur.c3 = 32'd7;
    cur_v = 1'b1; tick("lat1");
    chk("lat1.not_yet", 32'(b32.out_valid), 32'd0);
    cur_v = 1'b0; tick("lat2");
    chk("lat2.valid", 32'(b32.out_valid), 32'd1);
    chk("lat2.idx",   32'(b32.o__idx),    32'd3);
    chk("lat2.read",  b32.o__read,        32'd0);
    chk("lat2.write", b32.o__write,       32'd7);

    // Back-to-back same slot: forwarding
    cur = mk_add(1, 32'd1); cur_v = 1'b1;
    tick("b2b1");
    tick("b2b2"); chk("b2b.w1", b32.o__write, 32'd1);
    tick("b2b3"); chk("b2b.w2", b32.o__write, 32'd2);
    cur_v = 1'b0;
    tick("b2b4"); chk("b2b.w3", b32.o__write, 32'd3);

    // Interleaved slots 0/1
    pulse_reset("ilv");
    for (int k = 0; k < 4; k++) begin
      cur = mk_add(k % 2, 32'd10); cur_v = 1'b1;
      tick("ilv");
    end
    chk("ilv.s0", b32.o__write, 32'd20);
    chk("ilv.i0", 32'(b32.o__idx), 32'd0);
    cur_v = 1'b0;
    tick("ilv_end");
    chk("ilv.s1", b32.o__write, 32'd20);
    chk("ilv.i1", 32'(b32.o__idx), 32'd1);

    // Clear while an idx=2 packet is in stage B
    cur = mk_add(2, 32'd5); cur_v = 1'b1; tick("clr1");
    cur_v = 1'b0; tick("clr2");
    cur = mk_add(2, 32'd5); cur_v = 1'b1; tick("clr3");
    cur_v = 1'b0; cur_clr = 1'b1; tick("clr4");
    chk("clr.emit_valid", 32'(b32.out_valid), 32'd1);
    chk("clr.emit_read",  b32.o__read,        32'd5);
    chk("clr.emit_write", b32.o__write,       32'd10);
    cur_clr = 1'b0;
    cur = mk_add(2, 32'd0); cur_v = 1'b1; tick("clr5");
    cur_v = 1'b0; tick("clr6");
    chk("clr.after_read", b32.o__read, 32'd0);

    // Reset between edges with packets in flight
    cur = mk_add(4, 32'd7); cur_v = 1'b1; tick("rif1");
    cur = mk_add(5, 32'd9); tick("rif2");
    pulse_reset("rif");
    cur_v = 1'b0;
    tick("rif3"); chk("rif.quiet1", 32'(b32.out_valid), 32'd0);
    tick("rif4"); chk("rif.quiet2", 32'(b32.out_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      cur = mk_add(i, 32'd0); cur_v = 1'b1;
      tick("rif_rd");
    end
    cur_v = 1'b0;
    tick("rif_rd_end");
    chk("rif.slot7_read", b32.o__read, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      cur = '0;
      cur.idx = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      cur.p1 = rval(); cur.p2 = rval();
      cur.c1 = rval(); cur.c2 = rval(); cur.c3 = rval();
      cur.s1 = 1'($urandom); cur.s3 = 1'($urandom); cur.s5 = 1'($urandom);
      cur.s2 = 2'($urandom); cur.s4 = 2'($urandom); cur.s6 = 2'($urandom);
      cur.op = 2'($urandom);
      cur_v   = ($urandom_range(0, 3) != 0);
      cur_clr = ($urandom_range(0, 19) == 0);
      tick("rnd");
    end
    cur_v = 1'b0; cur_clr = 1'b0;
    tick("drain1");
    tick("drain2");

    // 8-bit: wrap-around and signed vs unsigned compare
    p = mk_add(0, 32'd250); p.s3 = 1'b1;
    drive8(p, 1'b1); @(posedge clk); #1;
    p = mk_add(0, 32'd10);
    drive8(p, 1'b1); @(posedge clk); #1;
    p = mk_add(1, 32'd255); p.s3 = 1'b1;
    drive8(p, 1'b1); @(posedge clk); #1;
    chk("w8.wrap_s", 32'(b8s.o__write), 32'd4);
    chk("w8.wrap_u", 32'(b8u.o__write), 32'd4);
    chk("w8.wrap_rd", 32'(b8s.o__read), 32'd250);
    p = '0; p.idx = 3'd1; p.s1 = 1'b0; p.s2 = 2'd0; p.p1 = 32'd1; p.op = OPC_LT;
    p.s3 = 1'b1; p.s4 = 2'd2; p.c2 = 32'hAA;
    p.s5 = 1'b1; p.s6 = 2'd2; p.c3 = 32'h55;
    drive8(p, 1'b1); @(posedge clk); #1;
    drive8('0, 1'b0); @(posedge clk); #1;
    chk("cmp.valid_s", 32'(b8s.out_valid), 32'd1);
    chk("cmp.read_s",  32'(b8s.o__read),   32'hFF);
    chk("cmp.signed",   32'(b8s.o__write), 32'hAA);
    chk("cmp.unsigned", 32'(b8u.o__write), 32'h55);
    @(posedge clk); #1;
    chk("cmp.bubble", 32'(b8s.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
